// File: rtl/gus16_bus_pkg.sv
// Shared state encoding, pin-bus phase codes and sizing helpers for the
// CPU-to-pin-bus bridge.
package gus16_bus_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_WDATA,
        ST_TURN,
        ST_RDATA,
        ST_DONE
    } state_t;

    localparam logic [1:0] PH_IDLE  = 2'b00;
    localparam logic [1:0] PH_ADDR  = 2'b01;
    localparam logic [1:0] PH_WDATA = 2'b10;
    localparam logic [1:0] PH_RDATA = 2'b11;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Bits needed to hold the value n-1, never less than one.
    function automatic int cnt_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/beat_shifter.sv
// PIN_W-slice MS-first shift register with parallel load; the MS slice feeds
// the pins and the LS slice is refilled from the pins on each shift.
module beat_shifter #(
    parameter int W     = 16,
    parameter int PIN_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [W-1:0]     load_val_i,
    input  logic             shift_i,
    input  logic [PIN_W-1:0] shift_in_i,
    output logic [PIN_W-1:0] ms_o,
    output logic [W-1:0]     shifted_o
);

    logic [W-1:0] word_q;

    generate
        if (W == PIN_W) begin : g_single
            assign shifted_o = shift_in_i;
        end else begin : g_multi
            assign shifted_o = {word_q[W-PIN_W-1:0], shift_in_i};
        end
    endgenerate

    assign ms_o = word_q[W-1 -: PIN_W];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word_q <= '0;
        end else if (load_i) begin
            word_q <= load_val_i;
        end else if (shift_i) begin
            word_q <= shifted_o;
        end
    end

endmodule

// File: rtl/pin_bus_bridge.sv
// Serialises CPU read/write transfers onto a narrow bidirectional pin bus:
// address beats, then write-data beats or a turnaround plus read-data beats.
module pin_bus_bridge
    import gus16_bus_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16,
    parameter int PIN_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              busy,
    output logic              ack,
    output logic [DATA_W-1:0] rdata,
    output logic [PIN_W-1:0]  pin_out,
    input  logic [PIN_W-1:0]  pin_in,
    output logic [PIN_W-1:0]  pin_oe,
    output logic [1:0]        phase,
    input  logic              ext_wait
);

    localparam int AB    = ADDR_W / PIN_W;
    localparam int DB    = DATA_W / PIN_W;
    localparam int SH_W  = max_int(ADDR_W, DATA_W);
    localparam int CNT_W = cnt_width(max_int(AB, DB));
    localparam logic [CNT_W-1:0] AB_LAST = CNT_W'(AB - 1);
    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DB - 1);

    state_t              state_q;
    logic [CNT_W-1:0]    cnt_q;
    logic                we_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [DATA_W-1:0]   rdata_q;
    logic                busy_q;
    logic                ack_q;
    logic [1:0]          phase_q;
    logic [PIN_W-1:0]    oe_q;

    logic                advance;
    logic                sh_load;
    logic                sh_shift;
    logic [SH_W-1:0]     sh_load_val;
    logic [SH_W-1:0]     sh_shifted;
    logic [PIN_W-1:0]    sh_ms;

    assign advance = !ext_wait;

    // One shifter serves both directions: words are left-aligned so the MS
    // slice is always the next outgoing beat, and read beats enter at the LS end.
    always_comb begin
        sh_load     = 1'b0;
        sh_shift    = 1'b0;
        sh_load_val = SH_W'(addr) << (SH_W - ADDR_W);
        case (state_q)
            ST_IDLE:  sh_load = req;
            ST_ADDR: begin
                if (advance) begin
                    if (cnt_q == AB_LAST) begin
                        sh_load     = we_q;
                        sh_load_val = SH_W'(wdata_q) << (SH_W - DATA_W);
                    end else begin
                        sh_shift = 1'b1;
                    end
                end
            end
            ST_WDATA: sh_shift = advance && (cnt_q != DB_LAST);
            ST_RDATA: sh_shift = advance;
            default:  ;
        endcase
    end

    beat_shifter #(
        .W     (SH_W),
        .PIN_W (PIN_W)
    ) u_shifter (
        .clk        (clk),
        .rst        (rst),
        .load_i     (sh_load),
        .load_val_i (sh_load_val),
        .shift_i    (sh_shift),
        .shift_in_i (pin_in),
        .ms_o       (sh_ms),
        .shifted_o  (sh_shifted)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            rdata_q <= '0;
            busy_q  <= 1'b0;
            ack_q   <= 1'b0;
            phase_q <= PH_IDLE;
            oe_q    <= '0;
        end else begin
            ack_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (req) begin
                        we_q    <= we;
                        wdata_q <= wdata;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        phase_q <= PH_ADDR;
                        oe_q    <= '1;
                        state_q <= ST_ADDR;
                    end
                end
                ST_ADDR: begin
                    if (advance) begin
                        if (cnt_q == AB_LAST) begin
                            cnt_q <= '0;
                            if (we_q) begin
                                phase_q <= PH_WDATA;
                                state_q <= ST_WDATA;
                            end else begin
                                phase_q <= PH_IDLE;
                                oe_q    <= '0;
                                state_q <= ST_TURN;
                            end
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                end
                ST_WDATA: begin
                    if (advance) begin
                        if (cnt_q == DB_LAST) begin
                            cnt_q   <= '0;
                            phase_q <= PH_IDLE;
                            oe_q    <= '0;
                            ack_q   <= 1'b1;
                            state_q <= ST_DONE;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                end
                ST_TURN: begin
                    cnt_q   <= '0;
                    phase_q <= PH_RDATA;
                    state_q <= ST_RDATA;
                end
                ST_RDATA: begin
                    if (advance) begin
                        if (cnt_q == DB_LAST) begin
                            rdata_q <= sh_shifted[DATA_W-1:0];
                            cnt_q   <= '0;
                            phase_q <= PH_IDLE;
                            ack_q   <= 1'b1;
                            state_q <= ST_DONE;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    busy_q  <= 1'b0;
                    cnt_q   <= '0;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign busy    = busy_q;
    assign ack     = ack_q;
    assign rdata   = rdata_q;
    assign phase   = phase_q;
    assign pin_oe  = oe_q;
    assign pin_out = (state_q == ST_ADDR || state_q == ST_WDATA) ? sh_ms : '0;

endmodule

// File: doc/pin_bus_bridge.md
PIN_BUS_BRIDGE -- requirements
Module: pin_bus_bridge

Interface
REQ-001 Parameter ADDR_W, default 16: CPU address width in bits; must be a multiple of PIN_W.
REQ-002 Parameter DATA_W, default 16: CPU data width in bits; must be a multiple of PIN_W.
REQ-003 Parameter PIN_W, default 8: external bidirectional pin-bus width.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst  input  1  reset, asynchronous and active-high.
REQ-006 req  input  1  CPU transfer request; accepted only in IDLE.
REQ-007 we  input  1  1 = write, 0 = read; sampled with req.
REQ-008 addr  input  ADDR_W  transfer address; sampled with req.
REQ-009 wdata  input  DATA_W  write data; sampled with req.
REQ-010 busy  output  1  high from the cycle after acceptance through DONE.
REQ-011 ack  output  1  one-cycle completion pulse.
REQ-012 rdata  output  DATA_W  last read word; holds until the next read completes.
REQ-013 pin_out  output  PIN_W  beat driven onto the pins.
REQ-014 pin_in  input  PIN_W  beat sampled from the pins.
REQ-015 pin_oe  output  PIN_W  pin direction; all ones = drive, all zeros = input.
REQ-016 phase  output  2  beat type: 00 idle/turnaround, 01 address, 10 write data, 11 read data.
REQ-017 ext_wait  input  1  external stall; while high the current beat is held.

Function
REQ-018 The block SHALL derive AB = ADDR_W/PIN_W and DB = DATA_W/PIN_W.
REQ-019 The FSM SHALL have the states IDLE, ADDR, WDATA, TURN, RDATA and DONE.
REQ-020 In IDLE with req=1, the block SHALL latch we, addr and wdata and enter ADDR on the same edge.
REQ-021 In ADDR the block SHALL drive the address MS slice first, with phase=01 and pin_oe all ones, for AB beats.
REQ-022 A beat SHALL advance only on an edge where ext_wait=0; with ext_wait=1, pin_out, phase and the beat counter SHALL hold.
REQ-023 After the last ADDR beat, a write SHALL enter WDATA; a read SHALL enter TURN.
REQ-024 WDATA: wdata MS slice first, phase=10, pin_oe all ones, DB beats, then DONE.
REQ-025 TURN: exactly one cycle, independent of ext_wait, with pin_oe=0 and phase=00; then RDATA.
REQ-026 RDATA: pin_oe=0 and phase=11 for DB beats.
REQ-026a In RDATA, pin_in SHALL be shifted into rdata MS-first on each advancing edge.
REQ-027 DONE: ack=1 for exactly one cycle, busy=1, then IDLE; a req present in DONE is ignored.
REQ-028 Latency with ext_wait=0: ack SHALL be high on the 5th cycle after acceptance for a write (AB+DB+1) and on the 6th for a read (AB+1+DB+1), at the default parameters.
REQ-029 In IDLE and DONE: pin_out=0, pin_oe=0, phase=00.
REQ-030 pin_oe SHALL never be all ones in the cycle immediately following an RDATA beat (turnaround guaranteed).
REQ-031 The beat counter SHALL be sized to hold max(AB,DB)-1 and SHALL reset to 0 on every state entry.

Reset
REQ-032 While rst=1: state=IDLE, busy=0, ack=0, rdata=0, pin_out=0, pin_oe=0, phase=00, and all latches and counters 0.
REQ-033 rst asserted mid-transfer SHALL abort immediately, with no ack pulse; the first accepted req after release SHALL start a clean transfer.

Structure
REQ-034 The state encoding and the phase codes (PH_IDLE, PH_ADDR, PH_WDATA, PH_RDATA) SHALL live in a shared package, gus16_bus_pkg.
REQ-035 One sub-module, beat_shifter, SHALL be used: a PIN_W-slice MS-first load/shift register with an enable, used for both the outgoing and the capture paths.

Verification
REQ-036 Write, no wait: req, we=1, addr=0x12AB, wdata=0xBEEF. Pins SHALL show 0x12 and 0xAB with phase 01, then 0xBE and 0xEF with phase 10, with ack on cycle 5.
REQ-037 Read, no wait: req, we=0, addr=0x0040, pin_in=0xCA then 0xFE on the RDATA beats. Pins SHALL show 0x00, 0x40, then TURN with oe=0; ack SHALL come on cycle 6 with rdata=0xCAFE.
REQ-038 Wait states: ext_wait=1 for 3 cycles during the second ADDR beat. pin_out SHALL hold 0xAB for those cycles and ack SHALL slip by exactly 3 cycles.
REQ-039 Back-to-back requests: req held high continuously. Transfers SHALL be separated by DONE→IDLE, with one ack per transfer and no missed or duplicated transfer.
REQ-040 Reset mid-read: rst during the RDATA beat 1. Outputs SHALL go to reset values asynchronously, with no ack; the next read SHALL return correct data.
REQ-041 Parameter sweep PIN_W=4, ADDR_W=DATA_W=16: 4 address beats and 4 data beats; write ack on cycle 9; read on cycle 10.
